// File: rtl/array_ctrl_if.sv
// Control/SRAM/inst bundle between the host sequencer port and array_ctrl.
// The master side issues start and base addresses; the slave (array_ctrl) drives the rest.
interface array_ctrl_if #(
  parameter int ROW     = 8,
  parameter int ADDR_BW = 11
);
  logic               start;
  logic [ADDR_BW-1:0] w_base;
  logic [ADDR_BW-1:0] x_base;
  logic               busy;
  logic               done;
  logic               tile_rst;
  logic               w_rd_en;
  logic [ADDR_BW-1:0] w_addr;
  logic               x_rd_en;
  logic [ADDR_BW-1:0] x_addr;
  logic [2*ROW-1:0]   inst_w;

  modport master (
    output start, w_base, x_base,
    input  busy, done, tile_rst, w_rd_en, w_addr, x_rd_en, x_addr, inst_w
  );

  modport slave (
    input  start, w_base, x_base,
    output busy, done, tile_rst, w_rd_en, w_addr, x_rd_en, x_addr, inst_w
  );
endinterface

// File: rtl/array_ctrl.sv
// Run sequencer for the weight-stationary MAC-tile array: clear, kernel load, flush,
// activation stream, drain. Emits SRAM reads and per-row skewed 2-bit inst buses.
module array_ctrl #(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int LEN_NIJ = 36,
  parameter int ADDR_BW = 11,
  parameter int CNT_BW  = 8
) (
  input  logic        clk,
  input  logic        reset,
  array_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    KLOAD  = 3'd2,
    KFLUSH = 3'd3,
    EXEC   = 3'd4,
    DRAIN  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [CNT_BW-1:0] KLOAD_LAST  = CNT_BW'(COL - 1);
  localparam logic [CNT_BW-1:0] KFLUSH_LAST = CNT_BW'((ROW > 1) ? ROW - 2 : 0);
  localparam logic [CNT_BW-1:0] EXEC_LAST   = CNT_BW'(LEN_NIJ - 1);
  localparam logic [CNT_BW-1:0] DRAIN_LAST  = CNT_BW'(ROW + COL - 2);

  state_t              state;
  logic [CNT_BW-1:0]   cnt;
  logic [ADDR_BW-1:0]  w_base_q;
  logic [ADDR_BW-1:0]  x_base_q;
  logic [1:0]          inst_p0;
  logic [1:0]          inst_row_p1 [ROW];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.start) state <= CLR;
        end
        CLR: begin
          cnt   <= '0;
          state <= KLOAD;
        end
        KLOAD: begin
          if (cnt == KLOAD_LAST) begin
            cnt   <= '0;
            state <= (ROW > 1) ? KFLUSH : EXEC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        KFLUSH: begin
          if (cnt == KFLUSH_LAST) begin
            cnt   <= '0;
            state <= EXEC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EXEC: begin
          if (cnt == EXEC_LAST) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Base addresses are pure data: captured on an accepted start, never reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      w_base_q <= bus.w_base;
      x_base_q <= bus.x_base;
    end
  end

  always_comb begin
    inst_p0 = 2'b00;
    if (state == KLOAD) inst_p0 = 2'b01;
    else if (state == EXEC) inst_p0 = 2'b10;
  end

  // ---- stage p1: one register aligns inst with 1-cycle SRAM data, then r-cycle row skew
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROW; r++) inst_row_p1[r] <= 2'b00;
    end else begin
      inst_row_p1[0] <= inst_p0;
      for (int r = 1; r < ROW; r++) inst_row_p1[r] <= inst_row_p1[r-1];
    end
  end

  for (genvar r = 0; r < ROW; r++) begin : g_row
    assign bus.inst_w[2*r +: 2] = inst_row_p1[r];
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.tile_rst = (state == CLR);
  assign bus.w_rd_en  = (state == KLOAD);
  assign bus.x_rd_en  = (state == EXEC);
  assign bus.w_addr   = bus.w_rd_en ? w_base_q + ADDR_BW'(cnt) : '0;
  assign bus.x_addr   = bus.x_rd_en ? x_base_q + ADDR_BW'(cnt) : '0;

endmodule
